alu_share_arbiter: RTL and testbench

//  Shares one combinational 32-bit ALU between two requesters (port 0, port 1), e.g. execute stage and branch/address unit.

---
 rtl/alu_share_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one external combinational ALU between two requesters. Each port has
// a valid/ready request channel and a valid/ready response channel. Only one
// operation is in flight at a time. The ALU operands come from registers, and
// the ALU result is captured into the owning port's response register.
//
// Sequence: IDLE (arbitrate/accept) -> EXEC (ALU settles, capture result)
//           -> RESP (hold result until consumed) -> IDLE
//
// Build option:
//   ARB_FIXED_PRIO_EN  When defined, port 0 always wins a tie. The last-grant
//                      register is still updated but is not used.
//                      When undefined (default), ties are resolved round-robin.
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // port 0 request
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_in1,
    input  logic [DATA_W-1:0] req0_in2,
    input  logic [FUNC_W-1:0] req0_func,
    // port 1 request
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_in1,
    input  logic [DATA_W-1:0] req1_in2,
    input  logic [FUNC_W-1:0] req1_func,
    // port 0 response
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    // port 1 response
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    // shared ALU
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [FUNC_W-1:0] alu_func,
    input  logic [DATA_W-1:0] alu_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_last_grant;   // port that won the most recent accept
    logic              r_owner;        // port whose operation is in flight
    logic [DATA_W-1:0] r_alu_in1;
    logic [DATA_W-1:0] r_alu_in2;
    logic [FUNC_W-1:0] r_alu_func;
    logic              r_rsp0_valid;
    logic [DATA_W-1:0] r_rsp0_data;
    logic              r_rsp1_valid;
    logic [DATA_W-1:0] r_rsp1_data;

    logic              w_grant;        // winning port index
    logic              w_grant_vld;    // at least one port is requesting
    logic              w_req0_ready;
    logic              w_req1_ready;
    logic              w_accept;
    logic              w_rsp_hs;       // owner's response consumed this cycle

    // Choose the winning port from the current request valids.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_vld = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_vld = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
            w_grant     = 1'b0;
`else
            // Round-robin: the port that did not win last time gets the tie.
            w_grant     = ~r_last_grant;
`endif
        end else if (req0_valid) begin
            w_grant_vld = 1'b1;
            w_grant     = 1'b0;
        end else if (req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant     = 1'b1;
        end else begin
            w_grant_vld = 1'b0;
            w_grant     = 1'b0;
        end
    end

    // Ready is combinational from valid. It is asserted only in IDLE, and
    // only for the single winning port.
    assign w_req0_ready = (r_state == ST_IDLE) & w_grant_vld & ~w_grant & req0_valid;
    assign w_req1_ready = (r_state == ST_IDLE) & w_grant_vld &  w_grant & req1_valid;
    assign w_accept     = w_req0_ready | w_req1_ready;

    assign w_rsp_hs = (r_state == ST_RESP) &
                      (r_owner ? (r_rsp1_valid & rsp1_ready)
                               : (r_rsp0_valid & rsp0_ready));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one EXEC cycle, then wait in RESP for the consumer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture the winner's operands, and remember the owner and last grant.
    // The ALU inputs hold their value between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_in1    <= {DATA_W{1'b0}};
            r_alu_in2    <= {DATA_W{1'b0}};
            r_alu_func   <= {FUNC_W{1'b0}};
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_alu_in1    <= w_grant ? req1_in1  : req0_in1;
            r_alu_in2    <= w_grant ? req1_in2  : req0_in2;
            r_alu_func   <= w_grant ? req1_func : req0_func;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
        end
    end

    // Port 0 response: load the ALU result in EXEC and clear it on handshake.
    // The data is kept after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_data  <= {DATA_W{1'b0}};
        end else if ((r_state == ST_EXEC) && !r_owner) begin
            r_rsp0_valid <= 1'b1;
            r_rsp0_data  <= alu_out;
        end else if (w_rsp_hs && !r_owner) begin
            r_rsp0_valid <= 1'b0;
        end
    end

    // Port 1 response: same behaviour as port 0, for the other owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp1_valid <= 1'b0;
            r_rsp1_data  <= {DATA_W{1'b0}};
        end else if ((r_state == ST_EXEC) && r_owner) begin
            r_rsp1_valid <= 1'b1;
            r_rsp1_data  <= alu_out;
        end else if (w_rsp_hs && r_owner) begin
            r_rsp1_valid <= 1'b0;
        end
    end

    assign req0_ready = w_req0_ready;
    assign req1_ready = w_req1_ready;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_data  = r_rsp0_data;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_data  = r_rsp1_data;
    assign alu_in1    = r_alu_in1;
    assign alu_in2    = r_alu_in2;
    assign alu_func   = r_alu_func;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed scenarios plus a long randomized run. Every cycle is checked against
// a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int DATA_W = 32;
    localparam int FUNC_W = 4;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DATA_W-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [FUNC_W-1:0] req0_func, req1_func;
    logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0] rsp0_data, rsp1_data;
    logic [DATA_W-1:0] alu_in1, alu_in2, alu_out;
    logic [FUNC_W-1:0] alu_func;

    int n_checks = 0;
    int n_fail   = 0;
    int seen_grant;

    // reference model state
    int              m_lg;
    bit              m_busy, m_pend;
    int              m_owner;
    logic [31:0]     m_res;
    bit              m_rsp_valid [2];
    logic [31:0]     m_rsp_data  [2];
    logic [31:0]     m_in1, m_in2;
    logic [3:0]      m_func;

    always #5 clk = ~clk;

    // Behavioural ALU: Func[3] inverts B and sets carry-in; 110/111 give 0.
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] f);
        logic [31:0] bb;
        bb = f[3] ? ~b : b;
        case (f[2:0])
            3'b000:  return a & bb;
            3'b001:  return a | bb;
            3'b010:  return a ^ bb;
            3'b011:  return ~(a | bb);
            3'b100:  return a + bb + {31'd0, f[3]};
            3'b101:  return {31'd0, ($signed(a) < $signed(b))};
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out = alu_ref(alu_in1, alu_in2, alu_func);

    alu_share_arbiter #(.DATA_W(DATA_W), .FUNC_W(FUNC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
        .req0_in2(req0_in2), .req0_func(req0_func),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
        .req1_in2(req1_in2), .req1_func(req1_func),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_func(alu_func), .alu_out(alu_out)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lg = 1; m_busy = 1'b0; m_pend = 1'b0; m_owner = 0;
        m_res = 32'd0; m_in1 = 32'd0; m_in2 = 32'd0; m_func = 4'd0;
        for (int i = 0; i < 2; i++) begin
            m_rsp_valid[i] = 1'b0;
            m_rsp_data[i]  = 32'd0;
        end
    endtask

    // One clock cycle. Call with inputs already driven (posedge + 1).
    // Checks all outputs at negedge, then advances the model at posedge.
    task automatic run_cycle();
        int   win;
        logic rr0, rr1;
        @(negedge clk);
        rr0 = rsp0_ready; rr1 = rsp1_ready;
        win = -1;
        if (!m_busy) begin
            if (req0_valid && req1_valid) win = FIXED_PRIO ? 0 : ((m_lg == 0) ? 1 : 0);
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
        end
        check_eq("req0_ready", req0_ready, win == 0);
        check_eq("req1_ready", req1_ready, win == 1);
        check_eq("rsp0_valid", rsp0_valid, m_rsp_valid[0]);
        check_eq("rsp1_valid", rsp1_valid, m_rsp_valid[1]);
        check_eq("rsp0_data",  rsp0_data,  m_rsp_data[0]);
        check_eq("rsp1_data",  rsp1_data,  m_rsp_data[1]);
        check_eq("alu_in1",    alu_in1,    m_in1);
        check_eq("alu_in2",    alu_in2,    m_in2);
        check_eq("alu_func",   alu_func,   m_func);
        seen_grant = req0_ready ? 0 : (req1_ready ? 1 : -1);
        @(posedge clk);
        if (win >= 0) begin
            m_busy  = 1'b1; m_pend = 1'b1; m_owner = win; m_lg = win;
            m_in1   = (win == 1) ? req1_in1  : req0_in1;
            m_in2   = (win == 1) ? req1_in2  : req0_in2;
            m_func  = (win == 1) ? req1_func : req0_func;
            m_res   = alu_ref(m_in1, m_in2, m_func);
        end else if (m_pend) begin
            m_rsp_valid[m_owner] = 1'b1;
            m_rsp_data[m_owner]  = m_res;
            m_pend = 1'b0;
        end else if (m_busy && m_rsp_valid[m_owner] && ((m_owner == 1) ? rr1 : rr0)) begin
            m_rsp_valid[m_owner] = 1'b0;
            m_busy = 1'b0;
        end
        #1;
    endtask

    task automatic drive_req(input int port, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] f);
        if (port == 0) begin
            req0_valid = 1'b1; req0_in1 = a; req0_in2 = b; req0_func = f;
        end else begin
            req1_valid = 1'b1; req1_in1 = a; req1_in2 = b; req1_func = f;
        end
    endtask

    task automatic idle_cycles(input int n);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check_eq("rst_rsp0_valid", rsp0_valid, 1'b0);
        check_eq("rst_rsp1_valid", rsp1_valid, 1'b0);
        check_eq("rst_rsp0_data",  rsp0_data,  32'd0);
        check_eq("rst_rsp1_data",  rsp1_data,  32'd0);
        check_eq("rst_alu_in1",    alu_in1,    32'd0);
        check_eq("rst_alu_func",   alu_func,   4'd0);
        check_eq("rst_req0_ready", req0_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // Single request, then check the result 2 edges after acceptance.
    task automatic directed(input int port, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] f, input logic [31:0] expv, input string tag);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        drive_req(port, a, b, f);
        run_cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        run_cycle();
        check_eq({tag, "_valid"}, (port == 1) ? rsp1_valid : rsp0_valid, 1'b1);
        check_eq({tag, "_data"},  (port == 1) ? rsp1_data  : rsp0_data,  expv);
        run_cycle();
    endtask

    initial begin
        int got[$];
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_in1 = 32'd0; req0_in2 = 32'd0; req0_func = 4'd0;
        req1_in1 = 32'd0; req1_in2 = 32'd0; req1_func = 4'd0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        model_reset();
        do_reset();

        // 1, 2, 6: single-port operations
        directed(0, 32'd5,  32'd7, 4'b0100, 32'd12, "t1_add");
        directed(1, 32'd10, 32'd3, 4'b1100, 32'd7,  "t2_sub");
        directed(1, 32'd3,  32'd5, 4'b1101, 32'd1,  "t2_slt");
        directed(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0110, 32'd0, "t6_undef");
        idle_cycles(2);

        // 3: both ports always valid; grants alternate (or stay on port 0)
        do_reset();
        for (int c = 0; c < 40 && got.size() < 6; c++) begin
            drive_req(0, $urandom, $urandom, 4'($urandom_range(0, 15)));
            drive_req(1, $urandom, $urandom, 4'($urandom_range(0, 15)));
            run_cycle();
            if (seen_grant >= 0) got.push_back(seen_grant);
        end
        check_eq("t3_grant_count", got.size(), 6);
        foreach (got[i]) check_eq("t3_grant", got[i], FIXED_PRIO ? 0 : (i % 2));
        idle_cycles(3);

        // 4: response back-pressure holds everything stable
        rsp0_ready = 1'b0;
        drive_req(0, 32'd21, 32'd21, 4'b0100);
        run_cycle();
        req0_valid = 1'b0;
        run_cycle();
        for (int i = 0; i < 5; i++) begin
            drive_req(0, $urandom, $urandom, 4'b0100);
            drive_req(1, $urandom, $urandom, 4'b0100);
            run_cycle();
        end
        check_eq("t4_held_data", rsp0_data, 32'd42);
        rsp0_ready = 1'b1;
        run_cycle();
        run_cycle();
        check_eq("t4_idle_after_release", seen_grant >= 0, 1'b1);
        idle_cycles(4);

        // 5: async reset in EXEC discards the operation; next tie goes to port 0
        drive_req(0, 32'd5, 32'd7, 4'b0100);
        run_cycle();
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rsp0_valid", rsp0_valid, 1'b0);
        check_eq("t5_rsp1_valid", rsp1_valid, 1'b0);
        check_eq("t5_alu_in1",    alu_in1,    32'd0);
        check_eq("t5_alu_in2",    alu_in2,    32'd0);
        check_eq("t5_alu_func",   alu_func,   4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        drive_req(0, 32'd1, 32'd2, 4'b0100);
        drive_req(1, 32'd3, 32'd4, 4'b0100);
        run_cycle();
        check_eq("t5_tie_after_reset", seen_grant, 0);
        idle_cycles(4);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_in1 = $urandom; req0_in2 = $urandom; req0_func = 4'($urandom_range(0, 15));
            req1_in1 = $urandom; req1_in2 = $urandom; req1_func = 4'($urandom_range(0, 15));
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            run_cycle();
        end
        idle_cycles(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
